// File: rtl/motor_step_gen.sv
// Step/direction generator for a stepper driver: direction setup delay, fixed-count
// 50 % duty step train, limit-switch stop and latched power-fail handling.
package motor_step_gen_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module motor_step_gen
  import motor_step_gen_pkg::*;
#(
  parameter int DIR_SETUP_CYC = 40,
  parameter int SYNC_STAGES   = 2
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [15:0] steps_ib16,
  input  logic [15:0] half_period_ib16,
  input  logic        boost_i,
  input  logic        clear_fault_i,
  input  logic        pl_pfail_i,
  input  logic        pl_sw_outa_i,
  input  logic        pl_sw_outb_i,
  output logic        pl_clk_o,
  output logic        pl_dir_o,
  output logic        pl_en_o,
  output logic        pl_boost_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        limit_stop_o,
  output logic        fault_o,
  output logic [15:0] steps_done_ob16
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, FAULT} state_t;

  localparam logic [15:0] SETUP_LEN = 16'(DIR_SETUP_CYC);

  state_t      state;
  logic [2:0]  sync_q [SYNC_STAGES];
  logic        pfail_s, sw_a_s, sw_b_s;
  logic [15:0] steps_q, half_q, cyc_cnt;
  logic        hi_due, end_due, step_blocked;

  always_ff @(posedge ClkRs_ix.clk) begin
    if (!ClkRs_ix.reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {pfail_s, sw_a_s, sw_b_s} = sync_q[SYNC_STAGES-1];

  // Only the switch we are travelling toward can stop the move.
  assign step_blocked = pl_dir_o ? sw_a_s : sw_b_s;

  assign hi_due  = ((state == SETUP) && (steps_q != 16'd0) && (cyc_cnt >= SETUP_LEN)) ||
                   ((state == PULSE_LO) && (cyc_cnt >= half_q) && (steps_done_ob16 < steps_q));
  assign end_due = ((state == SETUP) && (steps_q == 16'd0)) ||
                   ((state == PULSE_LO) && (cyc_cnt >= half_q) && (steps_done_ob16 >= steps_q));

  always_ff @(posedge ClkRs_ix.clk) begin
    if (!ClkRs_ix.reset) begin
      state           <= IDLE;
      steps_q         <= '0;
      half_q          <= '0;
      cyc_cnt         <= '0;
      pl_clk_o        <= 1'b0;
      pl_dir_o        <= 1'b0;
      pl_en_o         <= 1'b0;
      pl_boost_o      <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      limit_stop_o    <= 1'b0;
      fault_o         <= 1'b0;
      steps_done_ob16 <= '0;
    end else begin
      done_o <= 1'b0;
      if (pfail_s) begin
        state      <= FAULT;
        fault_o    <= 1'b1;
        pl_clk_o   <= 1'b0;
        pl_en_o    <= 1'b0;
        pl_boost_o <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !fault_o) begin
              steps_q         <= steps_ib16;
              half_q          <= (half_period_ib16 < 16'd2) ? 16'd2 : half_period_ib16;
              steps_done_ob16 <= '0;
              limit_stop_o    <= 1'b0;
              pl_dir_o        <= dir_i;
              pl_boost_o      <= boost_i;
              pl_en_o         <= 1'b1;
              pl_clk_o        <= 1'b0;
              busy_o          <= 1'b1;
              cyc_cnt         <= 16'd1;
              state           <= SETUP;
            end
          end
          // The limit check happens on the edge that would start the next pulse.
          SETUP, PULSE_LO: begin
            if (hi_due && !step_blocked) begin
              pl_clk_o        <= 1'b1;
              steps_done_ob16 <= steps_done_ob16 + 16'd1;
              cyc_cnt         <= 16'd1;
              state           <= PULSE_HI;
            end else if (hi_due || end_due) begin
              limit_stop_o <= hi_due;
              done_o       <= 1'b1;
              busy_o       <= 1'b0;
              pl_boost_o   <= 1'b0;
              pl_clk_o     <= 1'b0;
              state        <= IDLE;
            end else begin
              cyc_cnt <= cyc_cnt + 16'd1;
            end
          end
          PULSE_HI: begin
            if (cyc_cnt >= half_q) begin
              pl_clk_o <= 1'b0;
              cyc_cnt  <= 16'd1;
              state    <= PULSE_LO;
            end else begin
              cyc_cnt <= cyc_cnt + 16'd1;
            end
          end
          FAULT: begin
            if (clear_fault_i) begin
              fault_o <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen: step train timing, zero/clamp, limit stop,
// power-fail latch and clear, start while busy, mid-move reset.
module tb_motor_step_gen;
  import motor_step_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ckrs_t       clk_rs;
  logic        start_i = 1'b0, dir_i = 1'b0, boost_i = 1'b0, clear_fault_i = 1'b0;
  logic [15:0] steps_ib16 = '0, half_period_ib16 = '0;
  logic        pl_pfail_i = 1'b0, pl_sw_outa_i = 1'b0, pl_sw_outb_i = 1'b0;
  logic        pl_clk_o, pl_dir_o, pl_en_o, pl_boost_o;
  logic        busy_o, done_o, limit_stop_o, fault_o;
  logic [15:0] steps_done_ob16;

  int assertCount = 0;
  int failCount = 0;
  int riseAt [16];
  int fallAt [16];
  int riseCnt, fallCnt, doneIdx, doneCnt, faultIdx;
  bit timedOut;

  assign clk_rs = '{clk: clk, reset: rst_n};
  always #5 clk = ~clk;

  motor_step_gen #(.DIR_SETUP_CYC(40), .SYNC_STAGES(2)) dut (
    .ClkRs_ix(clk_rs), .start_i(start_i), .dir_i(dir_i), .steps_ib16(steps_ib16),
    .half_period_ib16(half_period_ib16), .boost_i(boost_i), .clear_fault_i(clear_fault_i),
    .pl_pfail_i(pl_pfail_i), .pl_sw_outa_i(pl_sw_outa_i), .pl_sw_outb_i(pl_sw_outb_i),
    .pl_clk_o(pl_clk_o), .pl_dir_o(pl_dir_o), .pl_en_o(pl_en_o), .pl_boost_o(pl_boost_o),
    .busy_o(busy_o), .done_o(done_o), .limit_stop_o(limit_stop_o), .fault_o(fault_o),
    .steps_done_ob16(steps_done_ob16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Issues a one-cycle start; returns on the first negedge where the DUT has seen it.
  task automatic applyStimulus(input logic dir, input logic [15:0] steps, input logic [15:0] half, input logic boost);
    @(negedge clk);
    dir_i = dir;
    steps_ib16 = steps;
    half_period_ib16 = half;
    boost_i = boost;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Samples once per negedge (index 0 = first busy cycle), records pl_clk edges,
  // done and fault, and optionally injects switch/pfail/restart events at given indices.
  task automatic watchMove(input int budget, input int swbIdx, input bit toggleA,
                           input int pfailIdx, input int restartIdx);
    int endIdx;
    logic prevClk;
    riseCnt = 0; fallCnt = 0; doneIdx = -1; doneCnt = 0; faultIdx = -1;
    timedOut = 1'b1; endIdx = -1;
    prevClk = pl_clk_o;
    for (int idx = 0; idx < budget; idx++) begin
      if (idx == swbIdx) pl_sw_outb_i = 1'b1;
      if (toggleA && (idx % 3 == 0)) pl_sw_outa_i = ~pl_sw_outa_i;
      if (idx == pfailIdx) pl_pfail_i = 1'b1;
      if (idx == restartIdx) begin
        start_i = 1'b1; dir_i = ~dir_i; steps_ib16 = 16'd7;
        half_period_ib16 = 16'd2; boost_i = ~boost_i;
      end else if (idx == restartIdx + 1) begin
        start_i = 1'b0;
      end
      if (pl_clk_o && !prevClk && riseCnt < 16) begin riseAt[riseCnt] = idx; riseCnt++; end
      if (!pl_clk_o && prevClk && fallCnt < 16) begin fallAt[fallCnt] = idx; fallCnt++; end
      if (done_o) begin doneCnt++; if (doneIdx < 0) doneIdx = idx; end
      if (fault_o && faultIdx < 0) faultIdx = idx;
      if (endIdx < 0 && (doneIdx >= 0 || faultIdx >= 0)) endIdx = idx + 3;
      prevClk = pl_clk_o;
      if (idx == endIdx) begin timedOut = 1'b0; break; end
      @(negedge clk);
    end
    pl_sw_outa_i = 1'b0;
    checkOutput("watch_timeout", 32'(timedOut), 0);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {pl_clk_o, pl_dir_o, pl_en_o, pl_boost_o, busy_o, done_o, limit_stop_o, fault_o}, 0);
    checkOutput("reset_steps_done", steps_done_ob16, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: 3 steps, half period 5, toward A, boost on
    applyStimulus(1'b1, 16'd3, 16'd5, 1'b1);
    checkOutput("nom_busy_first", busy_o, 1);
    checkOutput("nom_dir_first", pl_dir_o, 1);
    checkOutput("nom_en_first", pl_en_o, 1);
    checkOutput("nom_boost_first", pl_boost_o, 1);
    checkOutput("nom_clk_first", pl_clk_o, 0);
    watchMove(300, -1, 1'b0, -1, -1);
    checkOutput("nom_rises", riseCnt, 3);
    checkOutput("nom_rise0", riseAt[0], 40);
    checkOutput("nom_fall0", fallAt[0], 45);
    checkOutput("nom_rise1", riseAt[1], 50);
    checkOutput("nom_rise2", riseAt[2], 60);
    checkOutput("nom_fall2", fallAt[2], 65);
    checkOutput("nom_done_idx", doneIdx, 70);
    checkOutput("nom_done_width", doneCnt, 1);
    checkOutput("nom_steps_done", steps_done_ob16, 3);
    checkOutput("nom_idle_state", {busy_o, pl_en_o, pl_boost_o, limit_stop_o}, 4'b0100);

    // Zero steps: done right after setup starts, no step edge
    applyStimulus(1'b0, 16'd0, 16'd7, 1'b1);
    watchMove(100, -1, 1'b0, -1, -1);
    checkOutput("zero_rises", riseCnt, 0);
    checkOutput("zero_done_idx", doneIdx, 1);
    checkOutput("zero_done_width", doneCnt, 1);
    checkOutput("zero_steps_done", steps_done_ob16, 0);
    checkOutput("zero_boost_idle", pl_boost_o, 0);

    // Half period 0 clamps to 2
    applyStimulus(1'b0, 16'd2, 16'd0, 1'b0);
    watchMove(200, -1, 1'b0, -1, -1);
    checkOutput("clamp_rises", riseCnt, 2);
    checkOutput("clamp_rise0", riseAt[0], 40);
    checkOutput("clamp_fall0", fallAt[0], 42);
    checkOutput("clamp_rise1", riseAt[1], 44);
    checkOutput("clamp_fall1", fallAt[1], 46);
    checkOutput("clamp_done_idx", doneIdx, 48);

    // Limit B raised during 4th pulse, A toggling is irrelevant toward B
    applyStimulus(1'b0, 16'd10, 16'd5, 1'b0);
    watchMove(300, 72, 1'b1, -1, -1);
    checkOutput("limit_rises", riseCnt, 4);
    checkOutput("limit_rise3", riseAt[3], 70);
    checkOutput("limit_done_idx", doneIdx, 80);
    checkOutput("limit_done_width", doneCnt, 1);
    checkOutput("limit_flag", limit_stop_o, 1);
    checkOutput("limit_steps_done", steps_done_ob16, 4);
    pl_sw_outb_i = 1'b0;
    repeat (3) @(negedge clk);

    // Power fail during first high phase
    applyStimulus(1'b1, 16'd5, 16'd5, 1'b0);
    checkOutput("pf_limit_cleared", limit_stop_o, 0);
    watchMove(200, -1, 1'b0, 42, -1);
    checkOutput("pf_latency", faultIdx - 42, 3);
    checkOutput("pf_no_done", doneCnt, 0);
    checkOutput("pf_rises", riseCnt, 1);
    checkOutput("pf_outputs", {fault_o, pl_en_o, pl_clk_o, pl_boost_o, busy_o}, 5'b10000);
    applyStimulus(1'b1, 16'd3, 16'd5, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("pf_start_ignored", {busy_o, pl_en_o, fault_o}, 3'b001);
    pl_pfail_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pf_held_no_clear", fault_o, 1);
    clear_fault_i = 1'b1;
    @(negedge clk);
    clear_fault_i = 1'b0;
    checkOutput("pf_cleared", {fault_o, pl_en_o, busy_o}, 0);
    repeat (2) @(negedge clk);
    checkOutput("pf_idle_after_clear", {busy_o, pl_en_o}, 0);

    // Start while busy is ignored
    applyStimulus(1'b1, 16'd3, 16'd4, 1'b0);
    watchMove(300, -1, 1'b0, -1, 10);
    checkOutput("busy_rises", riseCnt, 3);
    checkOutput("busy_rise1", riseAt[1], 48);
    checkOutput("busy_fall2", fallAt[2], 60);
    checkOutput("busy_done_idx", doneIdx, 64);
    checkOutput("busy_steps_done", steps_done_ob16, 3);
    checkOutput("busy_dir_kept", pl_dir_o, 1);

    // Reset in the middle of a move
    applyStimulus(1'b1, 16'd5, 16'd5, 1'b1);
    repeat (45) @(negedge clk);
    checkOutput("rst_mid_busy", busy_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_outputs", {pl_clk_o, pl_dir_o, pl_en_o, pl_boost_o, busy_o, done_o, limit_stop_o, fault_o}, 0);
    checkOutput("rst_mid_steps", steps_done_ob16, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
